// File: rtl/spi_window_framebuffer_loader_pkg.sv
// Shared constants for the SPI window framebuffer loader.
// Opcodes and FSM encodings.
package spi_fb_pkg;

  localparam int BYTES_PER_ROW = 16;
  localparam int ROWS          = 96;
  localparam int ADDRESS_WIDTH = 11;
  localparam int DATA_WIDTH    = 8;

  localparam logic [7:0] OPC_SET_COL     = 8'h15;
  localparam logic [7:0] OPC_SET_ROW     = 8'h75;
  localparam logic [7:0] OPC_WRITE_START = 8'h5C;
  localparam logic [7:0] OPC_FILL        = 8'hA5;

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_PARAM_START = 3'd1;
  localparam logic [2:0] S_PARAM_END   = 3'd2;
  localparam logic [2:0] S_FILL_VALUE  = 3'd3;
  localparam logic [2:0] S_FILLING     = 3'd4;

endpackage

// File: rtl/spi_window_framebuffer_loader_if.sv
// SPI byte input side and RAM write side
// of the framebuffer loader.
interface spi_window_framebuffer_loader_if #(
  parameter int DW = 8,
  parameter int AW = 11
);
  logic          done;
  logic          start;
  logic          dc;
  logic [DW-1:0] data;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          busy;
  logic          error;

  modport slave (
    input  data, done, start, dc,
    output we, waddr, wdata, busy, error
  );

  modport master (
    output data, done, start, dc,
    input  we, waddr, wdata, busy, error
  );
endinterface

// File: rtl/spi_window_framebuffer_loader_addr.sv
// Window bounds and raster pointer; the row base
// is tracked incrementally so no multiplier is needed.
module window_address_generator #(
  parameter int BPR  = 16,
  parameter int ROWS = 96,
  parameter int AW   = 11,
  parameter int CW   = $clog2(BPR),
  parameter int RW   = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          reload,
  input  logic          step,
  input  logic          load_col,
  input  logic          load_row,
  input  logic [CW-1:0] col_lo,
  input  logic [CW-1:0] col_hi,
  input  logic [RW-1:0] row_lo,
  input  logic [RW-1:0] row_hi,
  output logic [AW-1:0] addr,
  output logic          last
);

  logic [CW-1:0] col_s, col_e, col, c_cur;
  logic [RW-1:0] row_s, row_e, row, r_cur;
  logic [AW-1:0] base_s, base, b_cur;

  // Shift-add over the row bits against a constant.
  function automatic logic [AW-1:0] base_of(
    input logic [RW-1:0] r
  );
    logic [AW-1:0] acc;
    acc = '0;
    for (int i = 0; i < RW; i++)
      if (r[i]) acc = acc + AW'(BPR << i);
    return acc;
  endfunction

  // A reload in the same cycle as a step steps from the window start.
  always_comb begin
    c_cur = reload ? col_s  : col;
    r_cur = reload ? row_s  : row;
    b_cur = reload ? base_s : base;
    addr  = b_cur + AW'(c_cur);
    last  = (c_cur == col_e) && (r_cur == row_e);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_s  <= '0;
      col_e  <= CW'(BPR - 1);
      row_s  <= '0;
      row_e  <= RW'(ROWS - 1);
      col    <= '0;
      row    <= '0;
      base   <= '0;
      base_s <= '0;
    end else if (load_col) begin
      col_s <= col_lo;
      col_e <= col_hi;
      col   <= col_lo;
      row   <= row_s;
      base  <= base_s;
    end else if (load_row) begin
      row_s  <= row_lo;
      row_e  <= row_hi;
      row    <= row_lo;
      base_s <= base_of(row_lo);
      base   <= base_of(row_lo);
      col    <= col_s;
    end else if (step) begin
      if (c_cur != col_e) begin
        col  <= c_cur + 1'b1;
        row  <= r_cur;
        base <= b_cur;
      end else begin
        col <= col_s;
        if (r_cur == row_e) begin
          row  <= row_s;
          base <= base_s;
        end else begin
          row  <= r_cur + 1'b1;
          base <= b_cur + AW'(BPR);
        end
      end
    end else if (reload) begin
      col  <= col_s;
      row  <= row_s;
      base <= base_s;
    end
  end

endmodule

// File: rtl/spi_window_framebuffer_loader.sv
// Command decoder and RAM write port for a windowed
// SPI framebuffer loader with hardware FILL.
import spi_fb_pkg::*;

module spi_window_framebuffer_loader #(
  parameter int BYTES_PER_ROW = spi_fb_pkg::BYTES_PER_ROW,
  parameter int ROWS          = spi_fb_pkg::ROWS,
  parameter int ADDRESS_WIDTH = spi_fb_pkg::ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = spi_fb_pkg::DATA_WIDTH
) (
  input logic clk,
  input logic rst_n,
  spi_window_framebuffer_loader_if.slave bus
);

  localparam int CW = $clog2(BYTES_PER_ROW);
  localparam int RW = $clog2(ROWS);

  logic [2:0]            state, st, nxt;
  logic                  cmd_row;
  logic [DATA_WIDTH-1:0] p_lo, fill_val;
  logic                  filling, cmd, dat, drop;
  logic                  reload, load_col, load_row;
  logic                  bad, valid;
  logic [31:0]           limit;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic                  last;

  assign filling = (state == S_FILLING);
  assign st      = (bus.start && !filling) ? S_IDLE : state;
  assign cmd     = bus.done && !bus.dc && !filling;
  assign dat     = bus.done && bus.dc && !filling;
  assign drop    = bus.done && filling;
  assign limit   = cmd_row ? 32'(ROWS) : 32'(BYTES_PER_ROW);
  assign valid   = (p_lo <= bus.data)
                && (32'(bus.data) < limit);

  always_comb begin
    nxt      = st;
    reload   = bus.start && !filling;
    load_col = 1'b0;
    load_row = 1'b0;
    bad      = 1'b0;
    if (cmd) begin
      unique case (st)
        S_IDLE: begin
          unique case (1'b1)
            (bus.data == OPC_SET_COL),
            (bus.data == OPC_SET_ROW):
              nxt = S_PARAM_START;
            (bus.data == OPC_FILL):
              nxt = S_FILL_VALUE;
            (bus.data == OPC_WRITE_START):
              reload = 1'b1;
            default: ;
          endcase
        end
        S_PARAM_START: nxt = S_PARAM_END;
        S_PARAM_END: begin
          nxt = S_IDLE;
          if (valid) begin
            load_col = !cmd_row;
            load_row = cmd_row;
          end else begin
            bad = 1'b1;
          end
        end
        S_FILL_VALUE: begin
          nxt    = S_FILLING;
          reload = 1'b1;
        end
        default: ;
      endcase
    end
    if (filling && last) nxt = S_IDLE;
  end

  window_address_generator #(
    .BPR  (BYTES_PER_ROW),
    .ROWS (ROWS),
    .AW   (ADDRESS_WIDTH)
  ) u_agen (
    .clk      (clk),
    .rst_n    (rst_n),
    .reload   (reload),
    .step     (dat || filling),
    .load_col (load_col),
    .load_row (load_row),
    .col_lo   (p_lo[CW-1:0]),
    .col_hi   (bus.data[CW-1:0]),
    .row_lo   (p_lo[RW-1:0]),
    .row_hi   (bus.data[RW-1:0]),
    .addr     (addr),
    .last     (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cmd_row   <= 1'b0;
      p_lo      <= '0;
      fill_val  <= '0;
      bus.we    <= 1'b0;
      bus.waddr <= '0;
      bus.wdata <= '0;
      bus.busy  <= 1'b0;
      bus.error <= 1'b0;
    end else begin
      state <= nxt;
      if (cmd && st == S_IDLE)
        cmd_row <= (bus.data == OPC_SET_ROW);
      if (cmd && st == S_PARAM_START)
        p_lo <= bus.data;
      if (cmd && st == S_FILL_VALUE)
        fill_val <= bus.data;
      bus.we <= dat || filling;
      if (dat || filling) begin
        bus.waddr <= addr;
        bus.wdata <= filling ? fill_val : bus.data;
      end
      bus.busy  <= filling;
      bus.error <= bad || drop;
    end
  end

endmodule

// File: tb/tb_spi_window_framebuffer_loader.sv
// Scoreboard bench for the windowed framebuffer
// loader: expected writes queued, observed writes matched.
module tb_spi_window_framebuffer_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  spi_window_framebuffer_loader_if #(
    .DW(8), .AW(11)
  ) bus ();

  spi_window_framebuffer_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #20 clk = ~clk;

  typedef struct {
    logic [10:0] a;
    logic [7:0]  d;
    int          c;
  } wr_t;

  wr_t exp_q[$];
  wr_t obs_q[$];
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int err_cnt = 0;
  int busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.we === 1'b1)
      obs_q.push_back('{bus.waddr, bus.wdata, cyc});
    if (bus.error === 1'b1) err_cnt <= err_cnt + 1;
    if (bus.busy === 1'b1) busy_cnt <= busy_cnt + 1;
  end

  task automatic send(input logic dcv,
                      input logic [7:0] b,
                      output int n);
    @(negedge clk);
    bus.dc = dcv;
    bus.data = b;
    bus.done = 1'b1;
    n = cyc;
    @(negedge clk);
    bus.done = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic cmd(input logic [7:0] b);
    int n;
    send(1'b0, b, n);
  endtask

  task automatic wr(input logic [7:0] b,
                    input logic [10:0] a);
    int n;
    send(1'b1, b, n);
    exp_q.push_back('{a, b, n + 1});
  endtask

  task automatic cs_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    bus.done = 0; bus.start = 0;
    bus.dc = 0; bus.data = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.we !== 1'b0 || bus.busy !== 1'b0 ||
        bus.error !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got we=%b busy=%b err=%b exp 0",
               bus.we, bus.busy, bus.error);
    end
    checks++;
    if (bus.waddr !== 11'd0 || bus.wdata !== 8'd0) begin
      failures++;
      $display("FAIL reset_bus got a=%0d d=%h exp 0",
               bus.waddr, bus.wdata);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_write();
    wr_t e, o;
    cs_start();
    wr(8'h11, 11'd0);
    wr(8'h22, 11'd1);
    wr(8'h33, 11'd2);
    repeat (4) @(negedge clk);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL basic_count got=%0d exp=%0d",
               obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.a !== e.a || o.d !== e.d || o.c !== e.c) begin
        failures++;
        $display("FAIL basic_wr got a=%0d d=%h c=%0d exp a=%0d d=%h c=%0d",
                 o.a, o.d, o.c, e.a, e.d, e.c);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_window_wrap();
    wr_t e, o;
    cmd(8'h15); cmd(8'd2); cmd(8'd3);
    cmd(8'h75); cmd(8'd5); cmd(8'd6);
    wr(8'hA0, 11'd82);
    wr(8'hA1, 11'd83);
    wr(8'hA2, 11'd98);
    wr(8'hA3, 11'd99);
    wr(8'hA4, 11'd82);
    repeat (4) @(negedge clk);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL wrap_count got=%0d exp=%0d",
               obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.a !== e.a || o.d !== e.d || o.c !== e.c) begin
        failures++;
        $display("FAIL wrap_wr got a=%0d d=%h c=%0d exp a=%0d d=%h c=%0d",
                 o.a, o.d, o.c, e.a, e.d, e.c);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_bad_window();
    wr_t e, o;
    int e0;
    int n;
    e0 = err_cnt;
    cmd(8'h15); cmd(8'd4); cmd(8'd2);
    checks++;
    if (err_cnt - e0 != 1) begin
      failures++;
      $display("FAIL bad_err_pulse got=%0d exp=1",
               err_cnt - e0);
    end
    cs_start();
    wr(8'hB0, 11'd82);
    wr(8'hB1, 11'd83);
    // start and data byte in the same cycle
    @(negedge clk);
    bus.start = 1'b1;
    bus.dc = 1'b1;
    bus.data = 8'hB2;
    bus.done = 1'b1;
    n = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    bus.done = 1'b0;
    exp_q.push_back('{11'd82, 8'hB2, n + 1});
    repeat (4) @(negedge clk);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL bad_count got=%0d exp=%0d",
               obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.a !== e.a || o.d !== e.d || o.c !== e.c) begin
        failures++;
        $display("FAIL bad_wr got a=%0d d=%h c=%0d exp a=%0d d=%h c=%0d",
                 o.a, o.d, o.c, e.a, e.d, e.c);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_fill();
    wr_t e, o;
    int e0, b0, n;
    cmd(8'h15); cmd(8'd0); cmd(8'd1);
    cmd(8'h75); cmd(8'd0); cmd(8'd1);
    cmd(8'hA5);
    e0 = err_cnt;
    b0 = busy_cnt;
    @(negedge clk);
    bus.dc = 1'b0;
    bus.data = 8'hFF;
    bus.done = 1'b1;
    n = cyc;
    @(negedge clk);
    bus.done = 1'b0;
    @(negedge clk);
    bus.dc = 1'b1;
    bus.data = 8'h77;
    bus.done = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
    exp_q.push_back('{11'd0,  8'hFF, n + 2});
    exp_q.push_back('{11'd1,  8'hFF, n + 3});
    exp_q.push_back('{11'd16, 8'hFF, n + 4});
    exp_q.push_back('{11'd17, 8'hFF, n + 5});
    repeat (8) @(negedge clk);
    checks++;
    if (busy_cnt - b0 != 4) begin
      failures++;
      $display("FAIL fill_busy got=%0d exp=4",
               busy_cnt - b0);
    end
    checks++;
    if (err_cnt - e0 != 1) begin
      failures++;
      $display("FAIL fill_drop_err got=%0d exp=1",
               err_cnt - e0);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL fill_count got=%0d exp=%0d",
               obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.a !== e.a || o.d !== e.d || o.c !== e.c) begin
        failures++;
        $display("FAIL fill_wr got a=%0d d=%h c=%0d exp a=%0d d=%h c=%0d",
                 o.a, o.d, o.c, e.a, e.d, e.c);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_abort();
    wr_t e, o;
    int e0;
    e0 = err_cnt;
    cmd(8'h15);
    cs_start();
    wr(8'h5A, 11'd0);
    cmd(8'h00);
    wr(8'h5B, 11'd1);
    wr(8'h5C, 11'd16);
    cmd(8'h75); cmd(8'd1); cmd(8'd1);
    wr(8'h6E, 11'd16);
    wr(8'h6F, 11'd17);
    repeat (4) @(negedge clk);
    checks++;
    if (err_cnt != e0) begin
      failures++;
      $display("FAIL abort_err got=%0d exp=0",
               err_cnt - e0);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL abort_count got=%0d exp=%0d",
               obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.a !== e.a || o.d !== e.d || o.c !== e.c) begin
        failures++;
        $display("FAIL abort_wr got a=%0d d=%h c=%0d exp a=%0d d=%h c=%0d",
                 o.a, o.d, o.c, e.a, e.d, e.c);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset_mid_fill();
    wr_t e, o;
    cmd(8'h15); cmd(8'd0); cmd(8'd15);
    cmd(8'h75); cmd(8'd0); cmd(8'd3);
    cmd(8'hA5);
    cmd(8'hC3);
    repeat (4) @(negedge clk);
    checks++;
    if (bus.we !== 1'b1 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL midfill_active got we=%b busy=%b exp 1",
               bus.we, bus.busy);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.we !== 1'b0 || bus.busy !== 1'b0 ||
        bus.waddr !== 11'd0 || bus.wdata !== 8'd0) begin
      failures++;
      $display("FAIL async_reset got we=%b busy=%b a=%0d d=%h exp 0",
               bus.we, bus.busy, bus.waddr, bus.wdata);
    end
    @(negedge clk);
    obs_q.delete();
    exp_q.delete();
    rst_n = 1'b1;
    cs_start();
    wr(8'h3C, 11'd0);
    wr(8'h3D, 11'd1);
    repeat (4) @(negedge clk);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL postreset_count got=%0d exp=%0d",
               obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.a !== e.a || o.d !== e.d || o.c !== e.c) begin
        failures++;
        $display("FAIL postreset_wr got a=%0d d=%h c=%0d exp a=%0d d=%h c=%0d",
                 o.a, o.d, o.c, e.a, e.d, e.c);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_window_wrap();
    test_bad_window();
    test_fill();
    test_abort();
    test_reset_mid_fill();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
